// File: rtl/mem_arb_pkg.sv
// Shared definitions for the main-memory port arbiter.
//   - arb_state_e : arbiter FSM encoding
//   - PORT_F/D    : requester identifiers (fetch / load-store)
//   - MEM_DEPTH   : words in the default 512-entry main memory
//   - addr_out_of_range : true when a word address lies beyond the array
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int ADDR_W_DEFAULT = 9;
    localparam int MEM_DEPTH      = 2 ** ADDR_W_DEFAULT;

    function automatic logic addr_out_of_range(input logic [31:0] addr, input int addr_w);
        return (addr >> addr_w) != 32'd0;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin grant.
//   clk, reset : system clock, synchronous active-high reset
//   req[1:0]   : request lines (bit 0 = fetch, bit 1 = data)
//   advance    : a grant is being taken this cycle; remember who won
//   gnt[1:0]   : one-hot (or zero) combinational grant
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // Holds the port granted most recently; the other one wins a tie.
    logic last_q, last_d;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last_q == PORT_F) ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        last_d = last_q;
        if (advance && (gnt != 2'b00)) begin
            last_d = gnt[1] ? PORT_D : PORT_F;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= PORT_F;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port level-sensitive main memory between instruction
// fetch (F) and load/store (D). Every output is registered so the memory
// strobes and address never glitch.
//
//   state  | meaning
//   IDLE   | waiting for a request; grants one and latches its address/data
//   ACCESS | strobes held WAIT_CYCLES cycles; read data captured on the last
//   DONE   | strobes low, one-cycle ack (and err) to the granted port
//
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   f_req/f_addr/f_rdata/f_ack : fetch port (read only)
//   d_req/d_we/d_addr/d_wdata/d_rdata/d_ack : load/store port
//   err                        : pulses with ack for an out-of-range address
//   mem_addr/mem_wdata/mem_read/mem_write/mem_rdata : memory interface
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = $clog2(MEM_DEPTH),
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [31:0]       f_addr,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              err,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              port_q, port_d;
    logic              we_q, we_d;
    logic              oor_q, oor_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              f_ack_q, f_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              err_q, err_d;

    logic [1:0]        gnt;
    logic              grant_valid;
    logic              sel_port;
    logic              sel_we;
    logic              sel_oor;
    logic [31:0]       sel_addr;
    logic [DATA_W-1:0] load_data;

    assign grant_valid = (state_q == IDLE) && (gnt != 2'b00);
    assign sel_port    = gnt[1] ? PORT_D : PORT_F;
    assign sel_addr    = gnt[1] ? d_addr : f_addr;
    assign sel_we      = gnt[1] & d_we;
    assign sel_oor     = addr_out_of_range(sel_addr, ADDR_W);
    // An out-of-range load never strobes the memory, so it returns zero.
    assign load_data   = oor_q ? '0 : mem_rdata;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset   (reset),
        .req     ({d_req, f_req}),
        .advance (grant_valid),
        .gnt     (gnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            port_q      <= PORT_F;
            we_q        <= 1'b0;
            oor_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            f_rdata_q   <= '0;
            d_rdata_q   <= '0;
            f_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            port_q      <= port_d;
            we_q        <= we_d;
            oor_q       <= oor_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            f_rdata_q   <= f_rdata_d;
            d_rdata_q   <= d_rdata_d;
            f_ack_q     <= f_ack_d;
            d_ack_q     <= d_ack_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_valid) state_d = ACCESS;
            ACCESS:  if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs. Strobes are computed one edge
    // ahead so they rise on entry to ACCESS and fall on entry to DONE.
    always_comb begin
        cnt_d       = cnt_q;
        port_d      = port_q;
        we_d        = we_q;
        oor_d       = oor_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        f_rdata_d   = f_rdata_q;
        d_rdata_d   = d_rdata_q;
        f_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    port_d      = sel_port;
                    we_d        = sel_we;
                    oor_d       = sel_oor;
                    mem_addr_d  = sel_addr;
                    if (sel_we) mem_wdata_d = d_wdata;
                    mem_read_d  = !sel_we && !sel_oor;
                    mem_write_d = sel_we && !sel_oor;
                    cnt_d       = CNT_LOAD;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        if (port_q == PORT_D) d_rdata_d = load_data;
                        else                  f_rdata_d = load_data;
                    end
                    f_ack_d = (port_q == PORT_F);
                    d_ack_d = (port_q == PORT_D);
                    err_d   = oor_q;
                end else begin
                    cnt_d       = cnt_q - CNT_W'(1);
                    mem_read_d  = mem_read_q;
                    mem_write_d = mem_write_q;
                end
            end
            default: ;
        endcase
    end

    assign f_rdata   = f_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign f_ack     = f_ack_q;
    assign d_ack     = d_ack_q;
    assign err       = err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    // main instance, WAIT_CYCLES = 1
    logic        f_req, d_req, d_we;
    logic [31:0] f_addr, d_addr, d_wdata;
    logic [31:0] f_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        f_ack, d_ack, err, mem_read, mem_write;

    // second instance, WAIT_CYCLES = 3
    logic        f_req3, d_req3, d_we3;
    logic [31:0] f_addr3, d_addr3, d_wdata3;
    logic [31:0] f_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
    logic        f_ack3, d_ack3, err3, mem_read3, mem_write3;

    mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(1)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_ack(f_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .err(err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset),
        .f_req(f_req3), .f_addr(f_addr3), .f_rdata(f_rdata3), .f_ack(f_ack3),
        .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
        .d_rdata(d_rdata3), .d_ack(d_ack3), .err(err3),
        .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_read(mem_read3),
        .mem_write(mem_write3), .mem_rdata(mem_rdata3)
    );

    // memory models
    logic [31:0] mem [0:MEM_DEPTH-1];
    assign mem_rdata  = mem[mem_addr[8:0]];
    always @(posedge clk) if (mem_write) mem[mem_addr[8:0]] = mem_wdata;
    assign mem_rdata3 = 32'hC0DE_0000 | {23'd0, mem_addr3[8:0]};

    int cyc = 0;
    always @(posedge clk) cyc++;

    // strobe activity counters
    int rd_cnt = 0, wr_cnt = 0, addr_chg = 0, rd3_cnt = 0, addr3_chg = 0;
    logic        prev_rd = 1'b0, prev_rd3 = 1'b0;
    logic [31:0] prev_addr = '0, prev_addr3 = '0;
    always @(negedge clk) begin
        if (mem_read) rd_cnt++;
        if (mem_write) wr_cnt++;
        if (mem_read && prev_rd && mem_addr != prev_addr) addr_chg++;
        if (mem_read3) rd3_cnt++;
        if (mem_read3 && prev_rd3 && mem_addr3 != prev_addr3) addr3_chg++;
        prev_rd = mem_read; prev_addr = mem_addr;
        prev_rd3 = mem_read3; prev_addr3 = mem_addr3;
    end

    // scoreboard
    typedef struct { logic port; logic [31:0] rdata; logic err; } exp_t;
    typedef struct { string name; logic [31:0] act; logic [31:0] exp; } dchk_t;
    exp_t  sb_q[$];
    dchk_t dq[$];
    int checks = 0, errors = 0;

    task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
        dq.push_back('{n, a, e});
    endtask

    always @(negedge clk) begin
        exp_t  e;
        dchk_t d;
        while (dq.size() > 0) begin
            d = dq.pop_front();
            checks++;
            if (d.act !== d.exp) begin
                errors++;
                $display("FAIL %s actual=%0h required=%0h", d.name, d.act, d.exp);
            end
        end
        if (f_ack && d_ack) begin
            checks++; errors++;
            $display("FAIL dual_ack actual=1 required=0");
        end
        if (err && !f_ack && !d_ack) begin
            checks++; errors++;
            $display("FAIL err_without_ack actual=1 required=0");
        end
        if (f_ack || d_ack) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack actual=%0d%0d required=none", f_ack, d_ack);
            end else begin
                e = sb_q.pop_front();
                if (d_ack !== e.port) begin
                    errors++;
                    $display("FAIL ack_port actual=%0d required=%0d", d_ack, e.port);
                end else if ((e.port ? d_rdata : f_rdata) !== e.rdata) begin
                    errors++;
                    $display("FAIL rdata actual=%0h required=%0h",
                             e.port ? d_rdata : f_rdata, e.rdata);
                end else if (err !== e.err) begin
                    errors++;
                    $display("FAIL err actual=%0d required=%0d", err, e.err);
                end
            end
        end
    end

    // Single access; starts and ends at a negedge with the DUT idle.
    task automatic access(input logic port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input int exp_lat);
        int  t0, lat;
        bit  done;
        sb_q.push_back('{port, exp_rdata, exp_err});
        if (port) begin d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1; end
        else      begin f_addr = addr; f_req = 1'b1; end
        t0 = cyc; done = 0; lat = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (port ? d_ack : f_ack) begin done = 1; lat = cyc - t0; end
        end
        if (port) d_req = 1'b0; else f_req = 1'b0;
        if (!done) check("ack_timeout", 32'd1, 32'd0);
        else       check("latency", lat, exp_lat);
        @(negedge clk);
    endtask

    // Both ports request together; first_port is expected to win.
    task automatic contend(input logic first_port, input logic [31:0] fa, input logic [31:0] f_exp,
                           input logic [31:0] da, input logic [31:0] d_exp);
        int  t0, tf, td;
        if (first_port == PORT_D) begin
            sb_q.push_back('{PORT_D, d_exp, 1'b0});
            sb_q.push_back('{PORT_F, f_exp, 1'b0});
        end else begin
            sb_q.push_back('{PORT_F, f_exp, 1'b0});
            sb_q.push_back('{PORT_D, d_exp, 1'b0});
        end
        f_addr = fa; d_addr = da; d_we = 1'b0; f_req = 1'b1; d_req = 1'b1;
        t0 = cyc; tf = -1; td = -1;
        for (int i = 0; i < 30 && (f_req || d_req); i++) begin
            @(negedge clk);
            if (f_ack) begin f_req = 1'b0; tf = cyc - t0; end
            if (d_ack) begin d_req = 1'b0; td = cyc - t0; end
        end
        if (f_req || d_req) begin
            check("contend_timeout", 32'd1, 32'd0);
            f_req = 1'b0; d_req = 1'b0;
        end else if (first_port == PORT_D) begin
            check("contend_first_lat", td, 2);
            check("contend_gap", tf - td, 3);
        end else begin
            check("contend_first_lat", tf, 2);
            check("contend_gap", td - tf, 3);
        end
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int r0, w0, a0, t0, lat;
        bit done;
        logic [31:0] exp_d;
        for (int i = 0; i < MEM_DEPTH; i++) mem[i] = 32'h0;
        mem[0]     = 32'h0A00_0069;
        mem[9'h47] = 32'h1234_5678;
        reset = 1'b1;
        f_req = 0; d_req = 0; d_we = 0; f_addr = 0; d_addr = 0; d_wdata = 0;
        f_req3 = 0; d_req3 = 0; d_we3 = 0; f_addr3 = 0; d_addr3 = 0; d_wdata3 = 0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_ctrl", {27'd0, f_ack, d_ack, err, mem_read, mem_write}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_f_rdata", f_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_ctrl3", {27'd0, f_ack3, d_ack3, err3, mem_read3, mem_write3}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // fetch read
        r0 = rd_cnt;
        access(PORT_F, 1'b0, 32'h0, 32'h0, 32'h0A00_0069, 1'b0, 2);
        check("fetch_rd_cycles", rd_cnt - r0, 1);

        // store then load
        exp_d = 32'h0;
        w0 = wr_cnt;
        access(PORT_D, 1'b1, 32'h8E, 32'd9, exp_d, 1'b0, 2);
        check("store_wr_cycles", wr_cnt - w0, 1);
        check("store_mem_word", mem[9'h8E], 32'd9);
        access(PORT_D, 1'b0, 32'h8E, 32'h0, 32'd9, 1'b0, 2);
        exp_d = 32'd9;

        // contention: pointer back at F after reset -> D first
        pulse_reset();
        exp_d = 32'h0;
        contend(PORT_D, 32'h0, 32'h0A00_0069, 32'h8E, 32'd9);
        access(PORT_D, 1'b0, 32'h47, 32'h0, 32'h1234_5678, 1'b0, 2);
        contend(PORT_F, 32'h47, 32'h1234_5678, 32'h8E, 32'd9);
        exp_d = 32'd9;

        // out of range
        r0 = rd_cnt;
        access(PORT_D, 1'b0, 32'h0000_0200, 32'h0, 32'h0, 1'b1, 2);
        check("oor_load_no_read", rd_cnt - r0, 0);
        exp_d = 32'h0;
        w0 = wr_cnt;
        access(PORT_D, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, exp_d, 1'b1, 2);
        check("oor_store_no_write", wr_cnt - w0, 0);
        check("oor_store_no_alias", mem[0], 32'h0A00_0069);
        access(PORT_F, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1, 2);

        // reset during ACCESS of a load
        d_we = 1'b0; d_addr = 32'h47; d_req = 1'b1;
        @(negedge clk);
        check("mid_access_read", {31'd0, mem_read}, 32'd1);
        reset = 1'b1; d_req = 1'b0;
        @(negedge clk);
        check("reset_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("reset_no_ack", {30'd0, f_ack, d_ack}, 32'd0);
        end
        check("reset_d_rdata", d_rdata, 32'd0);
        access(PORT_F, 1'b0, 32'h8E, 32'h0, 32'd9, 1'b0, 2);

        // WAIT_CYCLES = 3 instance
        r0 = rd3_cnt; a0 = addr3_chg;
        d_we3 = 1'b0; d_addr3 = 32'h33; d_req3 = 1'b1;
        t0 = cyc; done = 0; lat = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (d_ack3) begin done = 1; lat = cyc - t0; end
        end
        d_req3 = 1'b0;
        if (!done) check("w3_timeout", 32'd1, 32'd0);
        else begin
            check("w3_latency", lat, 4);
            check("w3_rdata", d_rdata3, 32'hC0DE_0033);
            check("w3_err", {31'd0, err3}, 32'd0);
        end
        check("w3_read_cycles", rd3_cnt - r0, 3);
        check("w3_addr_stable", addr3_chg - a0, 0);
        check("w1_addr_stable", addr_chg, 0);

        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
